// File: rtl/fetch_queue_if.sv
// Fetch unit bus: instruction-memory req/ack side, redirect input and
// the valid/ready hand-off of {inst, pc} to decode.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;
    logic [CW-1:0]   count;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, count,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, count,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled fetch: PC generator, one-outstanding req/ack memory port and a
// DEPTH-entry {inst, pc} queue toward decode, flushed on redirect.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    fetch_queue_if.master fq
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    state_t          state, state_n;
    logic [XLEN-1:0] fetch_pc, fetch_pc_n;
    logic [XLEN-1:0] req_addr, req_addr_n;
    logic [CW-1:0]   cnt, count_next;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    entry_t          mem [DEPTH];

    logic            push, pop;
    logic [XLEN-1:0] pc_inc, rpc;

    assign pc_inc = fetch_pc + XLEN'(4);
    assign rpc    = {fq.redirect_pc[XLEN-1:2], 2'b00};

    assign push       = (state == REQ) && fq.imem_ack && !fq.redirect;
    assign pop        = fq.inst_valid && fq.inst_ready && !fq.redirect;
    assign count_next = cnt + CW'(push) - CW'(pop);

    assign fq.imem_req   = (state != IDLE);
    assign fq.imem_addr  = req_addr;
    assign fq.inst_valid = (cnt != '0);
    assign fq.inst       = fq.inst_valid ? mem[rd_ptr].inst : '0;
    assign fq.inst_pc    = fq.inst_valid ? mem[rd_ptr].pc   : '0;
    assign fq.count      = cnt;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_addr_n = req_addr;
        case (state)
            IDLE: begin
                if (fq.redirect) begin
                    fetch_pc_n = rpc;
                end else if (cnt < CW'(DEPTH)) begin
                    req_addr_n = fetch_pc;
                    state_n    = REQ;
                end
            end
            REQ: begin
                if (fq.imem_ack && fq.redirect) begin
                    fetch_pc_n = rpc;
                    state_n    = IDLE;
                end else if (fq.imem_ack) begin
                    fetch_pc_n = pc_inc;
                    // Chain the next request immediately while space remains.
                    if (count_next < CW'(DEPTH)) req_addr_n = pc_inc;
                    else                         state_n    = IDLE;
                end else if (fq.redirect) begin
                    fetch_pc_n = rpc;
                    state_n    = DROP;
                end
            end
            DROP: begin
                // Keep the stale request open until memory acks it.
                if (fq.redirect) fetch_pc_n = rpc;
                if (fq.imem_ack) state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_addr <= req_addr_n;
            if (fq.redirect) begin
                cnt    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                cnt <= count_next;
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= '{inst: fq.imem_rdata, pc: req_addr};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed table of per-cycle inputs and expected outputs for fetch_queue,
// followed by a hand-written redirect-during-drop sequence.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) fq ();

    fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq.master)
    );

    typedef struct {
        bit          rst;
        bit          ack;
        bit          redir;
        logic [31:0] rpc;
        bit          ready;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic v(input bit r, input bit a, input bit rd, input logic [31:0] rp,
                     input bit rdy, input bit q, input logic [31:0] ad,
                     input bit vl, input logic [31:0] pc, input int c);
        vec_t e;
        e = '{rst: r, ack: a, redir: rd, rpc: rp, ready: rdy,
              e_req: q, e_addr: ad, e_valid: vl, e_pc: pc, e_cnt: c};
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_outs(input int idx, input bit q, input logic [31:0] ad,
                            input bit vl, input logic [31:0] pc, input int c);
        logic [31:0] e_inst;
        e_inst = vl ? word_of(pc) : 32'h0;
        chk("imem_req",   idx, 32'(fq.imem_req),   32'(q));
        chk("imem_addr",  idx, fq.imem_addr,       ad);
        chk("inst_valid", idx, 32'(fq.inst_valid), 32'(vl));
        chk("inst",       idx, fq.inst,            e_inst);
        chk("inst_pc",    idx, fq.inst_pc,         vl ? pc : 32'h0);
        chk("count",      idx, 32'(fq.count),      32'(c));
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        fq.imem_ack    = 1'b0;
        fq.imem_rdata  = '0;
        fq.redirect    = 1'b0;
        fq.redirect_pc = '0;
        fq.inst_ready  = 1'b0;

        //   rst ack rdr rpc           rdy | req addr          vld pc            cnt
        // back-to-back fetch, 1/cycle
        v(0, 1, 0, 32'h0,         1,   0, 32'h0,         0, 32'h0,         0);
        v(0, 1, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0,         0);
        v(0, 1, 0, 32'h0,         1,   1, 32'h4,         1, 32'h0,         1);
        v(0, 1, 0, 32'h0,         1,   1, 32'h8,         1, 32'h4,         1);
        // decode stalls: fill to DEPTH, request stops
        v(0, 1, 0, 32'h0,         0,   1, 32'hC,         1, 32'h8,         1);
        v(0, 1, 0, 32'h0,         0,   1, 32'h10,        1, 32'h8,         2);
        v(0, 1, 0, 32'h0,         0,   1, 32'h14,        1, 32'h8,         3);
        v(0, 1, 0, 32'h0,         0,   0, 32'h14,        1, 32'h8,         4);
        v(0, 1, 0, 32'h0,         1,   0, 32'h14,        1, 32'h8,         4);
        // one pop frees a slot, exactly one new request
        v(0, 0, 0, 32'h0,         0,   0, 32'h14,        1, 32'hC,         3);
        v(0, 1, 0, 32'h0,         0,   1, 32'h18,        1, 32'hC,         3);
        v(0, 0, 0, 32'h0,         1,   0, 32'h18,        1, 32'hC,         4);
        // redirect with 3 queued and no open request
        v(0, 0, 1, 32'h100,       1,   0, 32'h18,        1, 32'h10,        3);
        v(0, 0, 0, 32'h0,         1,   0, 32'h18,        0, 32'h0,         0);
        // redirect while request open: drop it, refetch after the ack
        v(0, 0, 1, 32'h200,       1,   1, 32'h100,       0, 32'h0,         0);
        v(0, 0, 0, 32'h0,         1,   1, 32'h100,       0, 32'h0,         0);
        v(0, 1, 0, 32'h0,         1,   1, 32'h100,       0, 32'h0,         0);
        v(0, 0, 0, 32'h0,         1,   0, 32'h100,       0, 32'h0,         0);
        // misaligned redirect together with ack
        v(0, 1, 1, 32'h303,       1,   1, 32'h200,       0, 32'h0,         0);
        v(0, 0, 0, 32'h0,         1,   0, 32'h200,       0, 32'h0,         0);
        // PC wrap at the top of the address space
        v(0, 1, 1, 32'hFFFF_FFFF, 1,   1, 32'h300,       0, 32'h0,         0);
        v(0, 0, 0, 32'h0,         1,   0, 32'h300,       0, 32'h0,         0);
        v(0, 1, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'h0,         0);
        v(0, 1, 0, 32'h0,         1,   1, 32'h0,         1, 32'hFFFF_FFFC, 1);
        v(0, 1, 0, 32'h0,         0,   1, 32'h4,         1, 32'h0,         1);
        // reset mid-request with 2 entries queued
        v(1, 0, 0, 32'h0,         0,   1, 32'h8,         1, 32'h0,         2);
        v(0, 0, 0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         0);
        v(0, 1, 0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         0);
        // reset while dropping a request
        v(0, 0, 1, 32'h40,        0,   1, 32'h4,         1, 32'h0,         1);
        v(1, 0, 0, 32'h0,         0,   1, 32'h4,         0, 32'h0,         0);
        v(0, 0, 0, 32'h0,         0,   0, 32'h0,         0, 32'h0,         0);
        v(0, 1, 0, 32'h0,         0,   1, 32'h0,         0, 32'h0,         0);
        v(0, 0, 1, 32'h80,        0,   1, 32'h4,         1, 32'h0,         1);

        repeat (2) @(negedge clk);
        foreach (tbl[i]) begin
            chk_outs(i, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_cnt);
            rst            = tbl[i].rst;
            fq.imem_ack    = tbl[i].ack;
            fq.imem_rdata  = word_of(tbl[i].e_addr);
            fq.redirect    = tbl[i].redir;
            fq.redirect_pc = tbl[i].rpc;
            fq.inst_ready  = tbl[i].ready;
            @(negedge clk);
        end

        // In DROP: the ack arrives with a second redirect; the later target wins.
        chk_outs(100, 1'b1, 32'h4, 1'b0, 32'h0, 0);
        fq.imem_ack    = 1'b1;
        fq.imem_rdata  = word_of(32'h4);
        fq.redirect    = 1'b1;
        fq.redirect_pc = 32'hC0;
        fq.inst_ready  = 1'b1;
        @(negedge clk);
        chk_outs(101, 1'b0, 32'h4, 1'b0, 32'h0, 0);
        fq.imem_ack = 1'b0;
        fq.redirect = 1'b0;
        n = 0;
        @(negedge clk);
        while (!fq.imem_req && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("req_after_drop", 102, 32'(fq.imem_req), 32'h1);
        chk("addr_after_drop", 102, fq.imem_addr, 32'hC0);
        fq.imem_ack   = 1'b1;
        fq.imem_rdata = word_of(32'hC0);
        @(negedge clk);
        fq.imem_ack = 1'b0;
        chk_outs(103, 1'b1, 32'hC4, 1'b1, 32'hC0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
